// File: rtl/msi_snoop_ctrl.sv
// Snoop-side MSI coherence initiator: searches the remote cache, writes back or
// invalidates as needed, and returns the line plus the state the requester installs.
module msi_snoop_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_type,
    input  logic [10:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_state,
    output logic        rsp_from_cache,
    output logic        snp_search,
    output logic [10:0] snp_boci,
    output logic        snp_invalidate,
    input  logic        snp_found,
    input  logic [1:0]  snp_state,
    input  logic [4:0]  snp_tag,
    input  logic [63:0] snp_line,
    output logic        mem_re,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,
    output logic [15:0] inv_count
);
    localparam logic [1:0] ST_S   = 2'b01;
    localparam logic [1:0] ST_M   = 2'b10;
    localparam logic [1:0] T_RD   = 2'd0;
    localparam logic [1:0] T_UPGR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_WB     = 3'd2,
        S_INV    = 3'd3,
        S_MEMRD  = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    state_t      state_r;
    logic [1:0]  type_r;
    logic [10:0] addr_r;
    logic [63:0] line_r;
    logic        hit_r;
    logic        remote_hit_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? 16'hFFFF : (v + 16'd1);
    endfunction

    function automatic logic [1:0] install_state(input logic [1:0] t);
        install_state = (t == T_RD) ? ST_S : ST_M;
    endfunction

    // The remote search is indexed by addr[5:0] only, so the tag must match too.
    assign remote_hit_s = snp_found & (snp_tag == addr_r[10:6]);

    // Controller FSM; every output is registered and defaults to idle each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            type_r         <= 2'd0;
            addr_r         <= 11'd0;
            line_r         <= 64'd0;
            hit_r          <= 1'b0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= 64'd0;
            rsp_state      <= 2'd0;
            rsp_from_cache <= 1'b0;
            snp_search     <= 1'b0;
            snp_boci       <= 11'd0;
            snp_invalidate <= 1'b0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 11'd0;
            mem_wdata      <= 64'd0;
            inv_count      <= 16'd0;
        end else begin
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= 64'd0;
            rsp_state      <= 2'd0;
            rsp_from_cache <= 1'b0;
            snp_search     <= 1'b0;
            snp_boci       <= 11'd0;
            snp_invalidate <= 1'b0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 11'd0;
            mem_wdata      <= 64'd0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        type_r     <= (req_type == 2'd3) ? T_RD : req_type;
                        addr_r     <= req_addr;
                        snp_search <= 1'b1;
                        snp_boci   <= req_addr;
                        state_r    <= S_SEARCH;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    line_r <= snp_line;
                    hit_r  <= remote_hit_s;
                    if (remote_hit_s && (snp_state == ST_M) && (type_r != T_UPGR)) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_r;
                        mem_wdata <= snp_line;
                        state_r   <= S_WB;
                    end else if (remote_hit_s && (type_r != T_RD)) begin
                        snp_invalidate <= 1'b1;
                        snp_boci       <= addr_r;
                        state_r        <= S_INV;
                    end else if (remote_hit_s || (type_r == T_UPGR)) begin
                        // Shared read forward, or an upgrade nobody else holds.
                        rsp_valid      <= 1'b1;
                        rsp_state      <= install_state(type_r);
                        rsp_data       <= (type_r == T_UPGR) ? 64'd0 : snp_line;
                        rsp_from_cache <= remote_hit_s & (type_r != T_UPGR);
                        state_r        <= S_RESP;
                    end else begin
                        mem_re   <= 1'b1;
                        mem_addr <= addr_r;
                        state_r  <= S_MEMRD;
                    end
                end
                S_WB: begin
                    if (mem_rdy) begin
                        // The remote port cannot downgrade, so even a read invalidates it.
                        snp_invalidate <= 1'b1;
                        snp_boci       <= addr_r;
                        state_r        <= S_INV;
                    end else begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_r;
                        mem_wdata <= line_r;
                    end
                end
                S_INV: begin
                    inv_count      <= sat_inc(inv_count);
                    rsp_valid      <= 1'b1;
                    rsp_state      <= install_state(type_r);
                    rsp_data       <= (type_r == T_UPGR) ? 64'd0 : line_r;
                    rsp_from_cache <= hit_r & (type_r != T_UPGR);
                    state_r        <= S_RESP;
                end
                S_MEMRD: begin
                    if (mem_rdy) begin
                        line_r         <= mem_rdata;
                        rsp_valid      <= 1'b1;
                        rsp_state      <= install_state(type_r);
                        rsp_data       <= mem_rdata;
                        rsp_from_cache <= 1'b0;
                        state_r        <= S_RESP;
                    end else begin
                        mem_re   <= 1'b1;
                        mem_addr <= addr_r;
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// Directed bench for msi_snoop_ctrl: expected responses are queued when a request
// is driven and popped when rsp_valid appears; a small memory model answers after N cycles.
module tb_msi_snoop_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_type = 2'd0;
    logic [10:0] req_addr = 11'd0;
    logic        req_ready, rsp_valid, rsp_from_cache;
    logic [63:0] rsp_data;
    logic [1:0]  rsp_state;
    logic        snp_search, snp_invalidate;
    logic [10:0] snp_boci;
    logic        snp_found = 1'b0;
    logic [1:0]  snp_state = 2'd0;
    logic [4:0]  snp_tag = 5'd0;
    logic [63:0] snp_line = 64'd0;
    logic        mem_re, mem_we;
    logic [10:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
    logic        mem_rdy = 1'b0;
    logic [15:0] inv_count;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  state;
        logic        fc;
    } rsp_t;

    rsp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          mem_delay = 1;
    int          mem_cnt = 0;
    int          we_cycles = 0;
    int          re_cycles = 0;
    int          inv_cycles = 0;
    int          rsp_count = 0;
    int          rsp_before = 0;
    logic [10:0] cur_addr = 11'd0;
    logic [63:0] exp_wdata = 64'd0;

    msi_snoop_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_state(rsp_state),
        .rsp_from_cache(rsp_from_cache),
        .snp_search(snp_search), .snp_boci(snp_boci), .snp_invalidate(snp_invalidate),
        .snp_found(snp_found), .snp_state(snp_state), .snp_tag(snp_tag), .snp_line(snp_line),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .inv_count(inv_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Memory responder, snoop observer and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_cnt = 0;
            mem_rdy = 1'b0;
        end else begin
            if (mem_re || mem_we) begin
                mem_cnt++;
                mem_rdy = (mem_cnt >= mem_delay);
                check("mem_addr", 64'(mem_addr), 64'(cur_addr));
                if (mem_we) begin
                    we_cycles++;
                    check("mem_wdata", mem_wdata, exp_wdata);
                end else begin
                    re_cycles++;
                end
            end else begin
                mem_cnt = 0;
                mem_rdy = 1'b0;
            end
            if (snp_invalidate) begin
                inv_cycles++;
                check("inv_boci", 64'(snp_boci), 64'(cur_addr));
            end
            if (rsp_valid) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_state", 64'(rsp_state), 64'(e.state));
                    check("rsp_from_cache", 64'(rsp_from_cache), 64'(e.fc));
                end
            end
        end
    end

    task automatic run_req(input logic [1:0] t, input logic [10:0] a, input logic [63:0] d,
                           input logic [1:0] st, input logic fc, input int lat,
                           input int mdly, input bit pulse_busy);
        int got;
        rsp_t e;
        @(negedge clk);
        cur_addr   = a;
        mem_delay  = mdly;
        we_cycles  = 0;
        re_cycles  = 0;
        inv_cycles = 0;
        check("ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        e.data = d; e.state = st; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 0;
        for (int k = 1; k <= 40 && got == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("snp_search", 64'(snp_search), 64'd1);
                check("search_boci", 64'(snp_boci), 64'(a));
            end
            if (pulse_busy && k == 1) begin
                req_valid = 1'b1;
                req_type  = 2'd1;
                req_addr  = ~a;
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid) got = k;
        end
        req_valid = 1'b0;
        check("latency", 64'(got), 64'(lat));
        @(negedge clk);
        check("idle_ready", 64'(req_ready), 64'd1);
        check("idle_no_rsp", 64'(rsp_valid), 64'd0);
        check("idle_boci", 64'(snp_boci), 64'd0);
    endtask

    task automatic set_remote(input logic f, input logic [1:0] s, input logic [4:0] tg,
                              input logic [63:0] ln);
        snp_found = f; snp_state = s; snp_tag = tg; snp_line = ln;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_inv_count", 64'(inv_count), 64'd0);
        check("rst_mem_re", 64'(mem_re), 64'd0);
        rst_n = 1'b1;

        // Remote SHARED read: forwarded at minimum latency
        set_remote(1'b1, 2'b01, 5'h03, 64'h1111_2222_3333_4444);
        run_req(2'd0, 11'h0C5, 64'h1111_2222_3333_4444, 2'b01, 1'b1, 2, 1, 1'b0);
        check("rd_s_inv", 64'(inv_cycles), 64'd0);
        check("rd_s_mem", 64'(we_cycles + re_cycles), 64'd0);

        // Remote MODIFIED, write miss: write-back for 3 cycles, then invalidate
        set_remote(1'b1, 2'b10, 5'h1F, 64'hA5A5_0000_FFFF_1234);
        exp_wdata = 64'hA5A5_0000_FFFF_1234;
        run_req(2'd1, 11'h7FF, 64'hA5A5_0000_FFFF_1234, 2'b10, 1'b1, 6, 3, 1'b0);
        check("rdx_we_cycles", 64'(we_cycles), 64'd3);
        check("rdx_inv", 64'(inv_cycles), 64'd1);
        check("rdx_inv_count", 64'(inv_count), 64'd1);

        // Tag mismatch is a miss: served from memory
        set_remote(1'b1, 2'b01, 5'h02, 64'h9999_9999_9999_9999);
        mem_rdata = 64'hDEAD_BEEF_0123_4567;
        run_req(2'd0, 11'h045, 64'hDEAD_BEEF_0123_4567, 2'b01, 1'b0, 4, 2, 1'b0);
        check("mis_re_cycles", 64'(re_cycles), 64'd2);
        check("mis_inv", 64'(inv_cycles), 64'd0);

        // Upgrade with remote miss: immediate, no data, no memory
        set_remote(1'b0, 2'b00, 5'h00, 64'h7777_7777_7777_7777);
        run_req(2'd2, 11'h0C5, 64'd0, 2'b10, 1'b0, 2, 1, 1'b0);
        check("upg_miss_mem", 64'(we_cycles + re_cycles), 64'd0);

        // Upgrade with remote SHARED hit: one invalidate
        set_remote(1'b1, 2'b01, 5'h03, 64'h7777_7777_7777_7777);
        run_req(2'd2, 11'h0C5, 64'd0, 2'b10, 1'b0, 3, 1, 1'b0);
        check("upg_hit_inv", 64'(inv_cycles), 64'd1);
        check("upg_hit_count", 64'(inv_count), 64'd2);

        // Reserved type acts as a read; remote miss, memory answers in one cycle
        set_remote(1'b0, 2'b00, 5'h00, 64'd0);
        mem_rdata = 64'h0F0F_F0F0_1234_5678;
        run_req(2'd3, 11'h3C0, 64'h0F0F_F0F0_1234_5678, 2'b01, 1'b0, 3, 1, 1'b1);
        check("rsv_re_cycles", 64'(re_cycles), 64'd1);
        check("rsv_rsp_count", 64'(rsp_count), 64'd6);

        // Saturation of the invalidate counter
        @(negedge clk);
        force dut.inv_count = 16'hFFFE;
        #1 release dut.inv_count;
        check("preload", 64'(inv_count), 64'hFFFE);
        set_remote(1'b1, 2'b01, 5'h0A, 64'hCAFE_0000_0000_0001);
        for (int i = 0; i < 3; i++) begin
            run_req(2'd1, 11'h2A1, 64'hCAFE_0000_0000_0001, 2'b10, 1'b1, 3, 1, (i == 2));
            check("sat_count", 64'(inv_count), 64'hFFFF);
        end
        check("sat_rsp_count", 64'(rsp_count), 64'd9);

        // Reset during a stalled memory read aborts the transaction
        set_remote(1'b0, 2'b00, 5'h00, 64'd0);
        mem_delay = 100000;
        cur_addr  = 11'h123;
        @(negedge clk);
        req_valid = 1'b1; req_type = 2'd0; req_addr = 11'h123;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_mem_re", 64'(mem_re), 64'd1);
        rsp_before = rsp_count;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_re", 64'(mem_re), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_inv_count", 64'(inv_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_count), 64'(rsp_before));
        check("abort_ready_after", 64'(req_ready), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/msi_snoop_ctrl.md
# msi_snoop_ctrl

Snoop-side coherence initiator for the two-core MSI system. It accepts one miss or upgrade request at a time from the requesting core's cache controller. It drives the remote cache's search and invalidate port and decides whether the line is sourced from the remote cache or from memory, performing any write-back first. It returns the data and the MSI state the requester must install. It sits between the two cache controllers and the shared memory port.

## Interface
Parameters:
- none; state encoding is fixed from common: INVALID=2'b00, SHARED=2'b01, MODIFIED=2'b10.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request from requesting cache controller.
- req_type  in  2  0=BUS_RD (read miss), 1=BUS_RDX (write miss), 2=BUS_UPGR (write hit to SHARED), 3=reserved.
- req_addr  in  11  line address {tag[4:0],index[5:0]}.
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  64  line data for the requester; 0 for BUS_UPGR.
- rsp_state  out  2  state to install: SHARED or MODIFIED.
- rsp_from_cache  out  1  1 = data forwarded from remote cache, 0 = from memory or no data.
- snp_search  out  1  remote cache search strobe.
- snp_boci  out  11  snooped address to remote cache.
- snp_invalidate  out  1  remote invalidate strobe.
- snp_found  in  1  remote line at index has state SHARED or MODIFIED.
- snp_state  in  2  remote line state.
- snp_tag  in  5  remote line tag.
- snp_line  in  64  remote line data.
- mem_re  out  1  memory line read.
- mem_we  out  1  memory line write (write-back).
- mem_addr  out  11  memory line address.
- mem_wdata  out  64  write-back data.
- mem_rdata  in  64  read data, valid when mem_rdy.
- mem_rdy  in  1  memory completes current access.
- inv_count  out  16  saturating count of invalidates issued.

## Operation
- FSM states are IDLE, SEARCH, WB, INV, MEMRD and RESP.
- On accept, the block latches req_type and req_addr into type_q and addr_q, then moves IDLE->SEARCH. A req_type of 3 is treated as BUS_RD.
- SEARCH lasts one cycle:
  - snp_search=1 and snp_boci=addr_q.
  - remote_hit = snp_found & (snp_tag==addr_q[10:6]). The tag compare is mandatory because the remote search indexes by addr_q[5:0] only.
  - On the exiting edge the block registers line_q=snp_line, rst_q=snp_state and hit_q=remote_hit.
- Transition out of SEARCH:
  - remote_hit & snp_state==MODIFIED & type in {RD,RDX} -> WB.
  - remote_hit & type in {RDX,UPGR} -> INV.
  - remote_hit & type==RD & state SHARED -> RESP, forwarding line_q.
  - !remote_hit & type==UPGR -> RESP.
  - !remote_hit otherwise -> MEMRD.
- WB:
  - mem_we=1, mem_addr=addr_q, mem_wdata=line_q, held until mem_rdy is sampled high.
  - Then -> INV.
- INV:
  - One cycle with snp_invalidate=1 and snp_boci=addr_q. inv_count increments, saturating at 16'hFFFF.
  - Then -> RESP.
  - BUS_RD of a MODIFIED line also invalidates the remote, because the remote port cannot downgrade.
- MEMRD:
  - mem_re=1 and mem_addr=addr_q, held until mem_rdy. mem_rdata is captured into line_q on that edge.
  - Then -> RESP.
- RESP:
  - One cycle with rsp_valid=1, then -> IDLE.
  - rsp_state = SHARED for BUS_RD, MODIFIED for BUS_RDX and BUS_UPGR.
  - rsp_data = line_q, or 0 for BUS_UPGR.
  - rsp_from_cache = hit_q & type!=UPGR.
- All snp_*/mem_* outputs are 0 when not in their owning state; snp_boci and mem_addr are 0 in IDLE.

## Timing
- Reset values:
  - State is IDLE; req_ready=1.
  - All other outputs are 0, including inv_count; internal registers are cleared.
- Reset asserted mid-transaction aborts immediately: outputs drop asynchronously and no rsp_valid follows.
- Accept on edge E0; SEARCH is the cycle E0–E1.
- Minimum latency (rsp_valid in cycle E1–E2) for:
  - remote SHARED BUS_RD;
  - remote-miss BUS_UPGR.
- Remote hit with INV and no WB: rsp_valid in E2–E3.
- WB or MEMRD add N cycles, where N is the number of cycles until mem_rdy is sampled high (N≥1). mem_rdy is ignored outside WB/MEMRD.
- req_valid outside IDLE is ignored and no request is queued. The earliest next accept is the edge ending RESP's following IDLE cycle.
- A tag mismatch with snp_found=1 is a miss; the remote line is left untouched.

## Test plan
- Reset mid-MEMRD: with mem_rdy held 0, drop rst_n -> mem_re=0 and req_ready=1 immediately; no rsp_valid after release.
- BUS_RD addr 11'h0C5, remote SHARED, tag 5'h03 -> rsp_valid exactly 2 cycles after accept, rsp_data=snp_line, rsp_state=SHARED, rsp_from_cache=1, no snp_invalidate.
- BUS_RDX addr 11'h7FF, remote MODIFIED, tag 5'h1F, mem_rdy after 3 cycles -> mem_we for 3 cycles with mem_wdata=line, then one snp_invalidate cycle, rsp_state=MODIFIED, inv_count=1.
- BUS_RD addr 11'h045, snp_found=1 but snp_tag=5'h02 (mismatch) -> MEMRD, rsp_data=mem_rdata=64'hDEAD_BEEF_0123_4567, rsp_from_cache=0, rsp_state=SHARED.
- BUS_UPGR with remote miss -> rsp_valid 2 cycles after accept, rsp_data=0, no memory access. BUS_UPGR with remote SHARED hit -> one invalidate, response 3 cycles after accept.
- Preload inv_count=16'hFFFE, run 3 invalidating requests -> inv_count stays 16'hFFFF; req_valid pulses during a busy transaction are ignored.
